// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller for a dual-port RAM with registered dataout.
// Generates RAM write/read strobes and addresses, tracks occupancy and
// keeps sticky overflow/underflow flags. rd_valid marks the cycle in which
// the RAM dataout holds the word released by an accepted pop.
module dpram_fifo_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    output logic              write_en,
    output logic              read_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] r_addr,
    output logic              rd_valid,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_AFULL = (ADDR_W + 1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   cnt;
    logic              push_acc;
    logic              pop_acc;

    // Flags, accept decisions and RAM-side signals, all derived from current state.
    // Push on full is refused even with a pop: wptr==rptr there and the RAM
    // bypass would hand back the new word instead of the stored one.
    always_comb begin
        full        = (cnt == CNT_DEPTH);
        almost_full = (cnt >= CNT_AFULL);
        empty       = (cnt == '0);
        push_acc    = push & ~full;
        pop_acc     = pop & ~empty;
        write_en    = push_acc;
        read_en     = pop_acc;
        w_addr      = wptr;
        r_addr      = rptr;
        count       = cnt;
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    // NOTE: state registers use non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_acc) wptr <= wptr + PTR_ONE;
            if (pop_acc)  rptr <= rptr + PTR_ONE;
            case ({push_acc, pop_acc})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // rd_valid tracks the RAM's one-cycle registered read latency.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_acc;
        end
    end

    // Sticky error flags; a new event in the same cycle beats err_clr.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= err_clr ? (push & full)  : (overflow  | (push & full));
            underflow <= err_clr ? (pop  & empty) : (underflow | (pop  & empty));
        end
    end

endmodule
